// File: rtl/pad_pkg.sv
// Shared types and constants for the VDD pad supply monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a (no data path).
package pad_pkg;

   // Power qualification state; the encoding is visible on the monitor's state port.
   typedef enum logic [1:0] {
      PWR_OFF  = 2'd0,
      PWR_RAMP = 2'd1,
      PWR_GOOD = 2'd2,
      PWR_HOLD = 2'd3
   } pwr_state_t;

   // Fewer than two flops does not give a metastable pad sample time to settle.
   localparam int PWR_SYNC_MIN = 2;

   // Larger of two integers; used to size the shared stability/hold counter.
   function automatic int pwr_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pad_sync.sv
// N-stage flop synchronizer for a single asynchronous level, reset to 0.
// Latency: N clk edges from d to q.
// Backpressure: none; a new sample is taken every edge.
//
// Ports:
//   clk  - sampling clock
//   rst  - synchronous active-high reset, clears every stage
//   d    - asynchronous input level
//   q    - synchronized level (last stage)
module pad_sync #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [N-1:0] stg;

   always_ff @(posedge clk) begin
      if (rst) begin
         stg <= '0;
      end else begin
         // Stage 0 captures d; every later stage copies its predecessor.
         stg <= {stg[N-2:0], d};
      end
   end

   assign q = stg[N-1];

endmodule

// File: rtl/pad_vdd_mon.sv
// VDD pad supply monitor: qualifies power-up, drives core reset / power-good, counts brownouts.
// Latency: pad rise to pwr_good is SYNC_STAGES+1+STABLE_CYCLES edges; pad fall to por_rst is SYNC_STAGES+1.
// Backpressure: none; the pad is sampled every edge and outputs are plain registered levels.
//
// Ports:
//   clk       - core clock
//   rst       - synchronous active-high reset, highest priority
//   pad       - VDD supply pad, sensed only (never driven from here)
//   rst_req   - software reset request level, acted on only while GOOD
//   por_rst   - registered core reset, high in every state except GOOD
//   pwr_good  - registered supply-qualified flag, high only in GOOD
//   brownout  - one-cycle pulse when a pad drop forces GOOD -> HOLD
//   bo_count  - saturating count of brownouts since reset
//   state     - current pwr_state_t
module pad_vdd_mon
   import pad_pkg::*;
#(
   parameter int ID            = 0,
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 16,
   parameter int HOLD_CYCLES   = 8,
   parameter int BO_W          = 8
) (
   input  logic            clk,
   input  logic            rst,
   inout  wire             pad,
   input  logic            rst_req,
   output logic            por_rst,
   output logic            pwr_good,
   output logic            brownout,
   output logic [BO_W-1:0] bo_count,
   output pwr_state_t      state
);

   // One counter serves both RAMP (stability) and HOLD (minimum reset time),
   // so it is sized for the longer of the two.
   localparam int CNT_MAX = pwr_max(STABLE_CYCLES, HOLD_CYCLES);
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0]   STABLE_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0]   HOLD_LAST   = CW'(HOLD_CYCLES - 1);
   localparam logic [BO_W-1:0] BO_MAX      = '1;

   // Elaboration-time guard against illegal parameterisations.
   if (SYNC_STAGES < PWR_SYNC_MIN || STABLE_CYCLES < 1 || HOLD_CYCLES < 1 ||
       BO_W < 1 || ID < 0) begin : g_bad_param
      $error("pad_vdd_mon: illegal parameter value");
   end

   logic          pad_s;
   logic [CW-1:0] cnt;

   // The pad is only read here; an undriven pad resolves to a non-1 level
   // after synchronization and therefore never qualifies as powered.
   pad_sync #(
      .N (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (pad),
      .q   (pad_s)
   );

   // Single FSM register block. por_rst and pwr_good are written alongside
   // every state change so they always reflect the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= PWR_OFF;
         cnt      <= '0;
         por_rst  <= 1'b1;
         pwr_good <= 1'b0;
         brownout <= 1'b0;
         bo_count <= '0;
      end else begin
         brownout <= 1'b0;
         case (state)
            PWR_OFF: begin
               if (pad_s) begin
                  state <= PWR_RAMP;
                  cnt   <= '0;
               end
               por_rst  <= 1'b1;
               pwr_good <= 1'b0;
            end

            PWR_RAMP: begin
               if (!pad_s) begin
                  // A drop before qualification is a glitch, not a brownout.
                  state <= PWR_OFF;
                  cnt   <= '0;
               end else if (cnt == STABLE_LAST) begin
                  state    <= PWR_GOOD;
                  cnt      <= '0;
                  por_rst  <= 1'b0;
                  pwr_good <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            PWR_GOOD: begin
               if (!pad_s) begin
                  // Pad loss wins over a simultaneous reset request.
                  state    <= PWR_HOLD;
                  cnt      <= '0;
                  por_rst  <= 1'b1;
                  pwr_good <= 1'b0;
                  brownout <= 1'b1;
                  if (bo_count != BO_MAX) begin
                     bo_count <= bo_count + 1'b1;
                  end
               end else if (rst_req) begin
                  state    <= PWR_HOLD;
                  cnt      <= '0;
                  por_rst  <= 1'b1;
                  pwr_good <= 1'b0;
               end
            end

            PWR_HOLD: begin
               // Pad and rst_req are deliberately ignored until the hold
               // time has elapsed so the core sees a full-length reset.
               if (cnt == HOLD_LAST) begin
                  state <= pad_s ? PWR_RAMP : PWR_OFF;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
               por_rst  <= 1'b1;
               pwr_good <= 1'b0;
            end

            default: begin
               state    <= PWR_OFF;
               cnt      <= '0;
               por_rst  <= 1'b1;
               pwr_good <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pad_vdd_mon.sv
module tb_pad_vdd_mon;

   localparam int SYNC   = 2;
   localparam int STABLE = 4;
   localparam int HOLD   = 3;
   localparam int BOW    = 2;
   localparam int BOMAX  = (1 << BOW) - 1;

   logic           clk;
   logic           rst;
   logic           pad_drv;
   wire            pad_w;
   logic           rst_req;
   logic           por_rst;
   logic           pwr_good;
   logic           brownout;
   logic [BOW-1:0] bo_count;
   logic [1:0]     state;

   assign pad_w = pad_drv;

   pad_vdd_mon #(
      .ID            (0),
      .SYNC_STAGES   (SYNC),
      .STABLE_CYCLES (STABLE),
      .HOLD_CYCLES   (HOLD),
      .BO_W          (BOW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pad      (pad_w),
      .rst_req  (rst_req),
      .por_rst  (por_rst),
      .pwr_good (pwr_good),
      .brownout (brownout),
      .bo_count (bo_count),
      .state    (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Modes: 0 off, 1 ramp, 2 good, 3 hold. 'left' is the number of further
   // edges remaining in the timed modes; pad_q is the synchronizer delay line.
   int   m_mode, m_left, m_cnt;
   bit   m_bo;
   bit   pad_q[$];

   function automatic void model_step(input bit r, input bit p, input bit req);
      bit ps;
      if (r) begin
         pad_q.delete();
         for (int k = 0; k < SYNC; k++) pad_q.push_back(1'b0);
         m_mode = 0; m_left = 0; m_cnt = 0; m_bo = 0;
         return;
      end
      ps = pad_q.pop_front();
      pad_q.push_back(p);
      m_bo = 0;
      case (m_mode)
         0: if (ps) begin m_mode = 1; m_left = STABLE; end
         1: begin
            if (!ps) m_mode = 0;
            else begin
               m_left = m_left - 1;
               if (m_left == 0) m_mode = 2;
            end
         end
         2: begin
            if (!ps) begin
               m_mode = 3; m_left = HOLD; m_bo = 1;
               m_cnt = (m_cnt < BOMAX) ? m_cnt + 1 : BOMAX;
            end else if (req) begin
               m_mode = 3; m_left = HOLD;
            end
         end
         default: begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_mode = ps ? 1 : 0;
               m_left = STABLE;
            end
         end
      endcase
   endfunction

   // One clock edge: update the model with the inputs present at the edge,
   // then compare every output shortly after the edge.
   task automatic tick();
      @(posedge clk);
      model_step(rst, pad_drv, rst_req);
      #1;
      chk("model state",    int'(state),    m_mode);
      chk("model por_rst",  int'(por_rst),  (m_mode != 2) ? 1 : 0);
      chk("model pwr_good", int'(pwr_good), (m_mode == 2) ? 1 : 0);
      chk("model brownout", int'(brownout), int'(m_bo));
      chk("model bo_count", int'(bo_count), m_cnt);
   endtask

   // Bounded wait for the DUT to reach a state; returns edges taken (lim on timeout).
   task automatic wait_state(input int tgt, input int lim, output int n);
      n = 0;
      while (int'(state) != tgt && n < lim) begin
         tick();
         n++;
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit       r, p, q;
      int       st;
      bit       por, good, bo;
      int       cnt;
   } vec_t;

   vec_t vt[32];

   function automatic vec_t mk(input bit r, input bit p, input bit q, input int st,
                               input bit por, input bit good, input bit bo, input int cnt);
      vec_t v;
      v.r = r; v.p = p; v.q = q; v.st = st;
      v.por = por; v.good = good; v.bo = bo; v.cnt = cnt;
      return v;
   endfunction

   initial begin
      int n;
      rst = 1'b1; pad_drv = 1'b0; rst_req = 1'b0;
      model_step(1'b1, 1'b0, 1'b0);

      // Power-up: GOOD on the 7th edge after pad rises.
      vt[0]  = mk(1,0,0, 0,1,0,0,0);
      vt[1]  = mk(1,0,0, 0,1,0,0,0);
      vt[2]  = mk(0,1,0, 0,1,0,0,0);
      vt[3]  = mk(0,1,0, 0,1,0,0,0);
      vt[4]  = mk(0,1,0, 1,1,0,0,0);
      vt[5]  = mk(0,1,0, 1,1,0,0,0);
      vt[6]  = mk(0,1,0, 1,1,0,0,0);
      vt[7]  = mk(0,1,0, 1,1,0,0,0);
      vt[8]  = mk(0,1,0, 2,0,1,0,0);
      // Brownout: one-cycle pad drop, pulse 3 edges later, HOLD 3, RAMP 4.
      vt[9]  = mk(0,0,0, 2,0,1,0,0);
      vt[10] = mk(0,1,0, 2,0,1,0,0);
      vt[11] = mk(0,1,0, 3,1,0,1,1);
      vt[12] = mk(0,1,0, 3,1,0,0,1);
      vt[13] = mk(0,1,0, 3,1,0,0,1);
      vt[14] = mk(0,1,0, 1,1,0,0,1);
      vt[15] = mk(0,1,0, 1,1,0,0,1);
      vt[16] = mk(0,1,0, 1,1,0,0,1);
      vt[17] = mk(0,1,0, 1,1,0,0,1);
      vt[18] = mk(0,1,0, 2,0,1,0,1);
      // Reset, then a ramp glitch: back to OFF with no brownout.
      vt[19] = mk(1,0,0, 0,1,0,0,0);
      vt[20] = mk(1,0,0, 0,1,0,0,0);
      vt[21] = mk(0,1,0, 0,1,0,0,0);
      vt[22] = mk(0,1,0, 0,1,0,0,0);
      vt[23] = mk(0,1,0, 1,1,0,0,0);
      vt[24] = mk(0,0,0, 1,1,0,0,0);
      vt[25] = mk(0,1,0, 1,1,0,0,0);
      vt[26] = mk(0,1,0, 0,1,0,0,0);
      vt[27] = mk(0,1,0, 1,1,0,0,0);
      vt[28] = mk(0,1,0, 1,1,0,0,0);
      vt[29] = mk(0,1,0, 1,1,0,0,0);
      vt[30] = mk(0,1,0, 1,1,0,0,0);
      vt[31] = mk(0,1,0, 2,0,1,0,0);

      for (int i = 0; i < 32; i++) begin
         rst = vt[i].r; pad_drv = vt[i].p; rst_req = vt[i].q;
         tick();
         chk($sformatf("vec%0d state", i),    int'(state),    vt[i].st);
         chk($sformatf("vec%0d por_rst", i),  int'(por_rst),  int'(vt[i].por));
         chk($sformatf("vec%0d pwr_good", i), int'(pwr_good), int'(vt[i].good));
         chk($sformatf("vec%0d brownout", i), int'(brownout), int'(vt[i].bo));
         chk($sformatf("vec%0d bo_count", i), int'(bo_count), vt[i].cnt);
      end

      // Saturation: five brownouts give counts 1,2,3,3,3 with a pulse each time.
      for (int i = 0; i < 5; i++) begin
         pad_drv = 1'b0; tick();
         pad_drv = 1'b1; tick(); tick();
         chk($sformatf("sat%0d pulse", i), int'(brownout), 1);
         chk($sformatf("sat%0d state", i), int'(state), 3);
         chk($sformatf("sat%0d count", i), int'(bo_count), (i + 1 < 3) ? i + 1 : 3);
         tick();
         chk($sformatf("sat%0d pulse width", i), int'(brownout), 0);
         wait_state(2, 30, n);
         chk($sformatf("sat%0d regood edges", i), n, 6);
      end

      // Reset request pulse.
      rst_req = 1'b1; tick();
      chk("req state", int'(state), 3);
      chk("req por_rst", int'(por_rst), 1);
      chk("req brownout", int'(brownout), 0);
      chk("req bo_count", int'(bo_count), 3);
      rst_req = 1'b0;
      wait_state(2, 30, n);
      chk("req regood edges", n, 7);

      // Held reset request cycles GOOD -> HOLD each round trip.
      rst_req = 1'b1;
      tick();
      chk("req held enter", int'(state), 3);
      for (int i = 0; i < 2; i++) begin
         wait_state(2, 30, n);
         chk($sformatf("req held trip%0d", i), n, 7);
         tick();
         chk($sformatf("req held rehold%0d", i), int'(state), 3);
      end
      rst_req = 1'b0;
      wait_state(2, 30, n);
      chk("req release edges", n, 7);

      // Mid-operation reset during RAMP with cnt=2.
      rst = 1'b1; tick();
      rst = 1'b0; pad_drv = 1'b1;
      tick(); tick(); tick(); tick(); tick();
      chk("ramp before rst", int'(state), 1);
      rst = 1'b1; tick();
      chk("rst ramp state", int'(state), 0);
      chk("rst ramp por", int'(por_rst), 1);
      chk("rst ramp good", int'(pwr_good), 0);
      chk("rst ramp count", int'(bo_count), 0);
      rst = 1'b0;
      tick(); chk("rst sync clear 1", int'(state), 0);
      tick(); chk("rst sync clear 2", int'(state), 0);
      tick(); chk("rst sync refill", int'(state), 1);

      // Mid-operation reset during HOLD, after building a nonzero count.
      wait_state(2, 30, n);
      chk("hold path good", n, 4);
      pad_drv = 1'b0; tick(); pad_drv = 1'b1; tick(); tick();
      chk("hold path count", int'(bo_count), 1);
      tick();
      rst = 1'b1; tick();
      chk("rst hold state", int'(state), 0);
      chk("rst hold por", int'(por_rst), 1);
      chk("rst hold count", int'(bo_count), 0);
      chk("rst hold pulse", int'(brownout), 0);
      rst = 1'b0;

      // Randomized stimulus against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 7) pad_drv = ~pad_drv;
         rst_req = ($urandom_range(0, 99) < 4);
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
